// File: rtl/regfile_pkg.sv
// Shared constants and the queued write-back entry type for the register-file
// write-back path.
package regfile_pkg;

  localparam int INDEX_BIT_WIDTH = 4;
  localparam int DATA_BIT_WIDTH  = 32;
  localparam int FIFO_DEPTH      = 4;

  typedef struct packed {
    logic [INDEX_BIT_WIDTH-1:0] index;
    logic [DATA_BIT_WIDTH-1:0]  data;
  } wb_entry;

endpackage

// File: rtl/regfile_writeback_wb_fifo.sv
// Generic synchronous FIFO holding {index,data} pairs, exposing per-slot valid
// and index so the owner can run hazard compares against every queued write.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int IW    = INDEX_BIT_WIDTH,
  parameter int DW    = DATA_BIT_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [IW-1:0]    i_push_index,
  input  logic [DW-1:0]    i_push_data,
  input  logic             i_pop,
  output logic [IW-1:0]    o_head_index,
  output logic [DW-1:0]    o_head_data,
  output logic [PW-1:0]    o_head_ptr,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count,
  output logic [DEPTH-1:0] o_ent_valid,
  output logic [IW-1:0]    o_ent_index [DEPTH]
);

  logic [IW-1:0] r_index [DEPTH];
  logic [DW-1:0] r_data  [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage is never reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (w_push_ok && !reset) begin
      r_index[r_wr_ptr] <= i_push_index;
      r_data[r_wr_ptr]  <= i_push_data;
    end
  end

  assign o_head_index = r_index[r_rd_ptr];
  assign o_head_data  = r_data[r_rd_ptr];
  assign o_head_ptr   = r_rd_ptr;

  // A slot is live when its distance from the read pointer is below count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign o_ent_valid[g] = ({1'b0, PW'(PW'(g) - r_rd_ptr)} < r_count);
    assign o_ent_index[g] = r_index[g];
  end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-back stage: arbitrates load and ALU results into an
// in-order write queue, drains it into the write port and flags read hazards.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int INDEX_BIT_WIDTH = regfile_pkg::INDEX_BIT_WIDTH,
  parameter int DATA_BIT_WIDTH  = regfile_pkg::DATA_BIT_WIDTH,
  parameter int FIFO_DEPTH      = regfile_pkg::FIFO_DEPTH,
  localparam int PW             = $clog2(FIFO_DEPTH),
  localparam int CW             = PW + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       memValid,
  input  logic [INDEX_BIT_WIDTH-1:0] memIndex,
  input  logic [DATA_BIT_WIDTH-1:0]  memData,
  output logic                       memReady,
  input  logic                       aluValid,
  input  logic [INDEX_BIT_WIDTH-1:0] aluIndex,
  input  logic [DATA_BIT_WIDTH-1:0]  aluData,
  output logic                       aluReady,
  input  logic                       wrtStall,
  output logic                       wrtEn,
  output logic [INDEX_BIT_WIDTH-1:0] wrtIndex,
  output logic [DATA_BIT_WIDTH-1:0]  wrtData,
  input  logic [INDEX_BIT_WIDTH-1:0] rdIndex1,
  input  logic [INDEX_BIT_WIDTH-1:0] rdIndex2,
  output logic                       pending1,
  output logic                       pending2,
  output logic [CW-1:0]              count,
  output logic                       empty
);

  logic                       w_full;
  logic                       w_empty;
  logic [CW-1:0]              w_count;
  logic [INDEX_BIT_WIDTH-1:0] w_head_index;
  logic [DATA_BIT_WIDTH-1:0]  w_head_data;
  logic [PW-1:0]              w_head_ptr;
  logic [FIFO_DEPTH-1:0]      w_ent_valid;
  logic [INDEX_BIT_WIDTH-1:0] w_ent_index [FIFO_DEPTH];
  logic                       w_mem_ready;
  logic                       w_alu_ready;
  logic                       w_push;
  logic [INDEX_BIT_WIDTH-1:0] w_push_index;
  logic [DATA_BIT_WIDTH-1:0]  w_push_data;
  logic                       w_wrt_en;
  logic                       w_show_head;
  logic                       w_pend1;
  logic                       w_pend2;

  // Readiness looks only at occupancy so a full queue never accepts, even
  // while its head is leaving; reset forces the idle-queue view.
  assign w_mem_ready  = reset || !w_full;
  assign w_alu_ready  = w_mem_ready && !memValid;
  assign w_push       = !reset && ((memValid && w_mem_ready) || (aluValid && w_alu_ready));
  assign w_push_index = memValid ? memIndex : aluIndex;
  assign w_push_data  = memValid ? memData  : aluData;

  assign w_show_head  = !reset && !w_empty;
  assign w_wrt_en     = w_show_head && !wrtStall;

  wb_fifo #(
    .IW    (INDEX_BIT_WIDTH),
    .DW    (DATA_BIT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_push_index (w_push_index),
    .i_push_data  (w_push_data),
    .i_pop        (w_wrt_en),
    .o_head_index (w_head_index),
    .o_head_data  (w_head_data),
    .o_head_ptr   (w_head_ptr),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (w_count),
    .o_ent_valid  (w_ent_valid),
    .o_ent_index  (w_ent_index)
  );

  // The head being written this cycle is forwarded by the register file, so
  // it no longer counts as a hazard.
  always_comb begin
    w_pend1 = 1'b0;
    w_pend2 = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_ent_valid[i] && !(w_wrt_en && (PW'(i) == w_head_ptr))) begin
        if (w_ent_index[i] == rdIndex1) w_pend1 = 1'b1;
        if (w_ent_index[i] == rdIndex2) w_pend2 = 1'b1;
      end
    end
  end

  assign memReady = w_mem_ready;
  assign aluReady = w_alu_ready;
  assign wrtEn    = w_wrt_en;
  assign wrtIndex = w_show_head ? w_head_index : '0;
  assign wrtData  = w_show_head ? w_head_data  : '0;
  assign pending1 = !reset && w_pend1;
  assign pending2 = !reset && w_pend2;
  assign count    = reset ? '0 : w_count;
  assign empty    = reset || w_empty;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed and randomized bench for regfile_writeback against a queue-based
// reference of the write-back behaviour.
module tb_regfile_writeback;
  import regfile_pkg::*;

  localparam int IW    = INDEX_BIT_WIDTH;
  localparam int DW    = DATA_BIT_WIDTH;
  localparam int DEPTH = FIFO_DEPTH;

  logic          clk = 1'b0;
  logic          reset;
  logic          memValid, aluValid, wrtStall;
  logic [IW-1:0] memIndex, aluIndex, rdIndex1, rdIndex2;
  logic [DW-1:0] memData, aluData;
  logic          memReady, aluReady, wrtEn, pending1, pending2, empty;
  logic [IW-1:0] wrtIndex;
  logic [DW-1:0] wrtData;
  logic [2:0]    count;

  wb_entry q[$];
  int n_checks = 0;
  int n_errors = 0;

  regfile_writeback #(
    .INDEX_BIT_WIDTH (IW),
    .DATA_BIT_WIDTH  (DW),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .memValid (memValid),
    .memIndex (memIndex),
    .memData  (memData),
    .memReady (memReady),
    .aluValid (aluValid),
    .aluIndex (aluIndex),
    .aluData  (aluData),
    .aluReady (aluReady),
    .wrtStall (wrtStall),
    .wrtEn    (wrtEn),
    .wrtIndex (wrtIndex),
    .wrtData  (wrtData),
    .rdIndex1 (rdIndex1),
    .rdIndex2 (rdIndex2),
    .pending1 (pending1),
    .pending2 (pending2),
    .count    (count),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs from the queue contents and the current inputs.
  task automatic compare_model();
    bit            full;
    bit            exp_mr, exp_ar, exp_we, p1, p2;
    logic [DW-1:0] exp_idx, exp_dat;
    full    = (q.size() == DEPTH);
    exp_mr  = reset ? 1'b1 : !full;
    exp_ar  = exp_mr && !memValid;
    exp_we  = !reset && (q.size() > 0) && !wrtStall;
    exp_idx = (!reset && q.size() > 0) ? DW'(q[0].index) : '0;
    exp_dat = (!reset && q.size() > 0) ? q[0].data : '0;
    p1 = 1'b0;
    p2 = 1'b0;
    if (!reset) begin
      foreach (q[k]) begin
        if (!(exp_we && k == 0)) begin
          if (q[k].index == rdIndex1) p1 = 1'b1;
          if (q[k].index == rdIndex2) p2 = 1'b1;
        end
      end
    end
    check("memReady", memReady, exp_mr);
    check("aluReady", aluReady, exp_ar);
    check("wrtEn",    wrtEn,    exp_we);
    check("wrtIndex", wrtIndex, exp_idx);
    check("wrtData",  wrtData,  exp_dat);
    check("count",    count,    reset ? '0 : DW'(q.size()));
    check("empty",    empty,    reset || q.size() == 0);
    check("pending1", pending1, p1);
    check("pending2", pending2, p2);
  endtask

  task automatic drive(input logic rst, input logic mv, input logic [IW-1:0] mi,
                       input logic [DW-1:0] md, input logic av, input logic [IW-1:0] ai,
                       input logic [DW-1:0] ad, input logic st,
                       input logic [IW-1:0] r1, input logic [IW-1:0] r2);
    @(negedge clk);
    reset    = rst;
    memValid = mv;  memIndex = mi;  memData = md;
    aluValid = av;  aluIndex = ai;  aluData = ad;
    wrtStall = st;  rdIndex1 = r1;  rdIndex2 = r2;
    #1;
    compare_model();
  endtask

  task automatic idle(input logic st);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, st, '0, '0);
  endtask

  // Advance one edge and apply the same edge to the reference queue.
  task automatic tick();
    bit has_room, acc_m, acc_a, deq;
    @(posedge clk);
    if (reset) begin
      q.delete();
    end else begin
      has_room = (q.size() < DEPTH);
      acc_m    = memValid && has_room;
      acc_a    = aluValid && !memValid && has_room;
      deq      = (q.size() > 0) && !wrtStall;
      if (deq) void'(q.pop_front());
      if (acc_m)      q.push_back('{index: memIndex, data: memData});
      else if (acc_a) q.push_back('{index: aluIndex, data: aluData});
    end
  endtask

  initial begin
    reset = 1'b1;
    memValid = 1'b0; memIndex = '0; memData = '0;
    aluValid = 1'b0; aluIndex = '0; aluData = '0;
    wrtStall = 1'b0; rdIndex1 = '0; rdIndex2 = '0;
    repeat (2) @(posedge clk);
    q.delete();

    // Reset state, and a request during reset must not be enqueued.
    drive(1'b1, 1'b1, 4'd6, 32'h1111, 1'b1, 4'd8, 32'h2222, 1'b0, 4'd6, 4'd8);
    check("rst_aluReady", aluReady, 1'b0);
    check("rst_count", count, '0);
    tick();
    idle(1'b0);
    check("rst_noenq", empty, 1'b1);
    tick();

    // Single write with one cycle of latency.
    drive(1'b0, 1'b1, 4'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, '0, '0);
    check("single_ready", memReady, 1'b1);
    check("single_nobypass", wrtEn, 1'b0);
    tick();
    idle(1'b0);
    check("single_en", wrtEn, 1'b1);
    check("single_idx", wrtIndex, 4'd5);
    check("single_dat", wrtData, 32'hDEADBEEF);
    tick();
    idle(1'b0);
    check("single_empty", empty, 1'b1);
    tick();

    // Load results win over ALU results.
    drive(1'b0, 1'b1, 4'd3, 32'h33, 1'b1, 4'd7, 32'h77, 1'b0, '0, '0);
    check("prio_mr", memReady, 1'b1);
    check("prio_ar", aluReady, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 4'd7, 32'h77, 1'b0, '0, '0);
    check("prio_first", wrtIndex, 4'd3);
    tick();
    idle(1'b0);
    check("prio_second", wrtIndex, 4'd7);
    tick();

    // Fill under stall; the fifth request waits until space frees.
    for (int k = 1; k <= 5; k++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1, IW'(k), DW'(k * 16), 1'b1, '0, '0);
      tick();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b1, 4'd5, 32'h50, 1'b0, '0, '0);
    check("fill_count", count, 3'd4);
    check("fill_full_rejects", aluReady, 1'b0);
    check("fill_w1", wrtIndex, 4'd1);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 4'd5, 32'h50, 1'b0, '0, '0);
    check("fill_ready", aluReady, 1'b1);
    check("fill_w2", wrtIndex, 4'd2);
    tick();
    for (int k = 3; k <= 5; k++) begin
      idle(1'b0);
      check("fill_drain", wrtIndex, IW'(k));
      tick();
    end
    idle(1'b0);
    tick();

    // Hazard lookup with the head excluded only while it is being written.
    drive(1'b0, 1'b1, 4'd2, 32'h22, 1'b0, '0, '0, 1'b1, '0, '0);
    tick();
    drive(1'b0, 1'b1, 4'd9, 32'h99, 1'b0, '0, '0, 1'b1, '0, '0);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'd9, 4'd2);
    check("haz_stall_p1", pending1, 1'b1);
    check("haz_stall_p2", pending2, 1'b1);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 4'd9, 4'd2);
    check("haz_p1", pending1, 1'b1);
    check("haz_p2", pending2, 1'b0);
    tick();
    idle(1'b0);
    tick();

    // Reset in the middle of a backlog discards every queued write.
    for (int k = 10; k <= 12; k++) begin
      drive(1'b0, 1'b1, IW'(k), DW'(k), 1'b0, '0, '0, 1'b1, '0, '0);
      tick();
    end
    drive(1'b1, 1'b1, 4'd13, 32'hD, 1'b0, '0, '0, 1'b0, 4'd10, 4'd11);
    check("mid_rst_en", wrtEn, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 4'd10, 4'd12);
      check("mid_rst_noemit", wrtEn, 1'b0);
      tick();
    end

    // Randomized traffic with alternating stall-heavy and drain-heavy phases.
    for (int n = 0; n < 600; n++) begin
      logic st;
      st = ((n / 40) % 2 == 1) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 2);
      drive(($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)), IW'($urandom_range(0, 5)),
            DW'($urandom), 1'($urandom_range(0, 1)), IW'($urandom_range(0, 5)), DW'($urandom),
            st, IW'($urandom_range(0, 5)), IW'($urandom_range(0, 5)));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 Parameter INDEX_BIT_WIDTH, default 4, register index width.
REQ-002 Parameter DATA_BIT_WIDTH, default 32, register data width.
REQ-003 Parameter FIFO_DEPTH, default 4, write-queue entries (power of two, >=2).
REQ-004 Port clk  in  1  the single clock; all state updates on posedge clk.
REQ-005 Port reset  in  1  reset, synchronous and active-high.
REQ-006 Ports memValid/memIndex/memData  in  1/4/32  load-result write request.
REQ-007 Port memReady  out  1  load request accepted when memValid&&memReady at posedge.
REQ-008 Ports aluValid/aluIndex/aluData  in  1/4/32  ALU-result write request.
REQ-009 Port aluReady  out  1  ALU request accepted when aluValid&&aluReady at posedge.
REQ-010 Port wrtStall  in  1  register-file write port borrowed; no write this cycle.
REQ-011 Ports wrtEn/wrtIndex/wrtData  out  1/4/32  drive register-file wrtEn/wrtIndex/dataIn.
REQ-012 Ports rdIndex1/rdIndex2  in  4 each  decode-stage read indices for hazard lookup.
REQ-013 Ports pending1/pending2  out  1 each  queued, not-yet-forwarded write targets rdIndexN.
REQ-014 Ports count/empty  out  3/1  queue occupancy 0..FIFO_DEPTH; empty = (count==0).

Function
REQ-015 Queue SHALL be in-order FIFO of {index,data}; at most one enqueue and one dequeue per cycle.
REQ-016 memReady SHALL equal !full; aluReady SHALL equal !full && !memValid (fixed priority mem over ALU).
REQ-017 Ready outputs SHALL NOT depend on wrtStall or same-cycle dequeue; full queue rejects even while draining.
REQ-018 wrtEn SHALL equal !empty && !wrtStall; wrtIndex/wrtData SHALL present head entry whenever !empty, and 0 when empty.
REQ-019 Dequeue SHALL occur at posedge iff wrtEn==1.
REQ-020 Latency: request accepted at edge N SHALL appear on wrtEn/wrtIndex/wrtData in cycle after edge N when queue was empty and wrtStall low; no same-cycle bypass from inputs.
REQ-021 Simultaneous enqueue and dequeue SHALL leave count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-022 pendingN SHALL be 1 iff some valid entry has index==rdIndexN, excluding the head entry when wrtEn==1 (the register file forwards it); input-side requests not yet accepted SHALL NOT count.
REQ-023 Multiple queued writes to one index SHALL all be performed in order; no coalescing.
REQ-024 Index 0 SHALL be treated as an ordinary register.
REQ-025 pending1/pending2/ready/wrtEn SHALL be combinational from registered state plus listed inputs; no other combinational input-to-output paths.

Reset
REQ-026 While reset==1 at posedge, pointers and count SHALL clear to 0, discarding queued entries, including mid-stream.
REQ-027 During and after reset: wrtEn=0, wrtIndex=0, wrtData=0, empty=1, count=0, pending1=pending2=0, memReady=1, aluReady=!memValid.
REQ-028 Requests presented in a cycle with reset high SHALL NOT be enqueued.
REQ-029 Entry storage need not be reset; valid tracking SHALL guarantee no stale entry affects outputs.

Structure
REQ-030 Shared package regfile_pkg SHALL hold INDEX_BIT_WIDTH, DATA_BIT_WIDTH, FIFO_DEPTH constants and the wb_entry {index,data} typedef.
REQ-031 One sub-module wb_fifo (generic synchronous FIFO with full/empty/count and per-entry valid/index visibility for hazard compare) SHALL be used; arbitration and hazard logic stay in regfile_writeback.

Verification
REQ-032 Single write: memValid=1,memIndex=5,memData=0xDEADBEEF one cycle -> next cycle wrtEn=1,wrtIndex=5,wrtData=0xDEADBEEF; then empty=1.
REQ-033 Priority: memValid and aluValid both 1 (mem idx 3, alu idx 7) -> memReady=1,aluReady=0; idx 3 written, then idx 7 after aluValid held.
REQ-034 Fill: wrtStall=1, five ALU requests idx 1..5 -> first four accepted, count=4, aluReady=0; release stall -> writes 1,2,3,4 on consecutive cycles, then 5 accepted.
REQ-035 Hazard: queue holds idx 9 behind head idx 2, wrtStall=0, rdIndex1=9, rdIndex2=2 -> pending1=1, pending2=0; with wrtStall=1 -> pending2=1.
REQ-036 Reset mid-operation: three entries queued, reset high one cycle -> count=0, wrtEn=0, pending=0; no queued write ever emitted.
